// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: playback control pulses and tone-generator drive signals
interface melody_sequencer_if;
  logic        start;
  logic        stop;
  logic        tone_en;
  logic [20:0] half_period;
  logic [2:0]  step_idx;
  logic        busy;
  logic        done;
  modport master (output start, stop, input tone_en, half_period, step_idx, busy, done);
  modport slave (input start, stop, output tone_en, half_period, step_idx, busy, done);
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer: 8-step melody player with articulation gaps; define LOOP_EN to repeat forever
module melody_sequencer #(
  parameter int CLK_MHZ     = 20,
  parameter int BEAT_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 200000
) (
  input logic               clk,
  input logic               rst_n,
  melody_sequencer_if.slave bus
);
  localparam int CW = $clog2(BEAT_CYCLES + 1);
  localparam logic [CW-1:0] PLAY_LAST = CW'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [2:0] MELODY [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  // Indexed by note code; code 0 is a rest and yields no period.
  localparam logic [20:0] HP [8] = '{
    21'd0, 21'(CLK_MHZ * 1911), 21'(CLK_MHZ * 1703), 21'(CLK_MHZ * 1517),
    21'(CLK_MHZ * 1432), 21'(CLK_MHZ * 1276), 21'(CLK_MHZ * 1136), 21'(CLK_MHZ * 1012)};
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] step, step_n, nxt, code_n;
  logic [20:0] hp, hp_n;
  logic tone, tone_n, busy, busy_n, done, done_n;
  assign bus.tone_en = tone;
  assign bus.half_period = hp;
  assign bus.step_idx = step;
  assign bus.busy = busy;
  assign bus.done = done;
  assign nxt = step + 3'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      step <= '0;
      hp <= '0;
      tone <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      step <= step_n;
      hp <= hp_n;
      tone <= tone_n;
      busy <= busy_n;
      done <= done_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    step_n = step;
    hp_n = hp;
    tone_n = tone;
    busy_n = busy;
    done_n = 1'b0;
    code_n = MELODY[nxt];
    if (bus.stop) begin
      state_n = IDLE;
      cnt_n = '0;
      step_n = '0;
      hp_n = '0;
      tone_n = 1'b0;
      busy_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (bus.start) begin
            state_n = PLAY;
            step_n = '0;
            hp_n = HP[MELODY[0]];
            tone_n = MELODY[0] != 3'd0;
            busy_n = 1'b1;
          end
        end
        PLAY:
          if (cnt == PLAY_LAST) begin
            state_n = GAP;
            cnt_n = '0;
            tone_n = 1'b0;
          end
        GAP:
          if (cnt == GAP_LAST) begin
            cnt_n = '0;
`ifdef LOOP_EN
            state_n = PLAY;
            step_n = nxt;
            hp_n = HP[code_n];
            tone_n = code_n != 3'd0;
`else
            // Step 7 finishes the melody; otherwise advance (nxt wraps to 0 only after 7).
            state_n = step == 3'd7 ? IDLE : PLAY;
            step_n = step == 3'd7 ? 3'd0 : nxt;
            hp_n = step == 3'd7 ? 21'd0 : HP[code_n];
            tone_n = step != 3'd7 && code_n != 3'd0;
            busy_n = step != 3'd7;
            done_n = step == 3'd7;
`endif
          end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
